// File: rtl/hs_skid_pkg.sv
// Shared state and occupancy encodings for the handshake skid buffer.
package hs_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam logic [1:0] LEVEL_EMPTY = 2'd0;
    localparam logic [1:0] LEVEL_ONE   = 2'd1;
    localparam logic [1:0] LEVEL_TWO   = 2'd2;

    function automatic logic [1:0] state_level(input skid_state_e st);
        logic [1:0] lvl;
        lvl = LEVEL_EMPTY;
        case (st)
            ST_BUSY: lvl = LEVEL_ONE;
            ST_FULL: lvl = LEVEL_TWO;
            default: lvl = LEVEL_EMPTY;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/hs_skid_buffer.sv
// Valid/ready skid buffer: s_ready is always a flop; REG_FWD also registers the
// forward path (two-entry pipeline), otherwise the payload passes straight through.
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | nothing held, upstream may send
// ST_BUSY  | output register holds one beat
// ST_FULL  | output register and skid register hold a beat each
module hs_skid_buffer
    import hs_skid_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int REG_FWD    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            level
);

    if (REG_FWD != 0) begin : g_fwd
        skid_state_e           state_q;
        skid_state_e           state_d;
        logic [DATA_WIDTH-1:0] out_q;
        logic [DATA_WIDTH-1:0] skid_q;
        logic                  ready_q;
        logic                  valid_q;
        logic [1:0]            level_q;
        logic                  in_xfer;
        logic                  out_xfer;
        logic                  load_out;
        logic                  load_skid;
        logic                  out_from_skid;

        assign in_xfer  = s_valid & ready_q;
        assign out_xfer = m_ready & valid_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= ST_EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d       = state_q;
            load_out      = 1'b0;
            load_skid     = 1'b0;
            out_from_skid = 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        load_out = 1'b1;
                        state_d  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        load_out = 1'b1;
                    end else if (in_xfer) begin
                        load_skid = 1'b1;
                        state_d   = ST_FULL;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        load_out      = 1'b1;
                        out_from_skid = 1'b1;
                        state_d       = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Handshake outputs are decoded from the next state so they arrive as flops.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ready_q <= 1'b0;
                valid_q <= 1'b0;
                level_q <= LEVEL_EMPTY;
                out_q   <= '0;
                skid_q  <= '0;
            end else begin
                ready_q <= (state_d != ST_FULL);
                valid_q <= (state_d != ST_EMPTY);
                level_q <= state_level(state_d);
                if (load_out) begin
                    out_q <= out_from_skid ? skid_q : s_data;
                end
                if (load_skid) begin
                    skid_q <= s_data;
                end
            end
        end

        assign s_ready = ready_q;
        assign m_valid = valid_q;
        assign m_data  = out_q;
        assign level   = level_q;
    end else begin : g_comb
        logic [DATA_WIDTH-1:0] skid_q;
        logic                  skid_valid_q;
        logic                  skid_valid_d;
        logic                  ready_q;
        logic                  in_xfer;

        assign in_xfer = s_valid & ready_q;

        always_comb begin
            skid_valid_d = skid_valid_q;
            if (skid_valid_q) begin
                if (m_ready) begin
                    skid_valid_d = 1'b0;
                end
            end else if (in_xfer && !m_ready) begin
                skid_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                skid_valid_q <= 1'b0;
                ready_q      <= 1'b0;
                skid_q       <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                ready_q      <= ~skid_valid_d;
                if (!skid_valid_q && in_xfer && !m_ready) begin
                    skid_q <= s_data;
                end
            end
        end

        // Pass-through is gated by ready_q so a beat offered in the first cycle
        // after reset is not presented downstream before upstream sees it accepted.
        assign s_ready = ready_q;
        assign m_valid = skid_valid_q | (s_valid & ready_q);
        assign m_data  = skid_valid_q ? skid_q : s_data;
        assign level   = skid_valid_q ? LEVEL_ONE : LEVEL_EMPTY;
    end

endmodule

// File: tb/tb_hs_skid_buffer.sv
// Bench for hs_skid_buffer: directed checks on the registered variant, then
// random valid/ready traffic on both variants against a queue reference model.
module tb_hs_skid_buffer;

    logic        clk;
    logic        rst;
    logic [15:0] s_data  [2];
    logic        s_valid [2];
    logic        s_ready [2];
    logic [15:0] m_data  [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic [1:0]  level   [2];

    int checks = 0;
    int errors = 0;

    // Reference model: beats accepted upstream and not yet delivered downstream.
    logic [15:0] mdl [2][0:32767];
    int          head [2];
    int          tail [2];
    int          emitted [2];
    logic        acc [2];
    logic        em [2];
    logic        sr_before [2];

    hs_skid_buffer #(.DATA_WIDTH(16), .REG_FWD(0)) u_comb (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data[0]),
        .s_valid (s_valid[0]),
        .s_ready (s_ready[0]),
        .m_data  (m_data[0]),
        .m_valid (m_valid[0]),
        .m_ready (m_ready[0]),
        .level   (level[0])
    );

    hs_skid_buffer #(.DATA_WIDTH(16), .REG_FWD(1)) u_fwd (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data[1]),
        .s_valid (s_valid[1]),
        .s_ready (s_ready[1]),
        .m_data  (m_data[1]),
        .m_valid (m_valid[1]),
        .m_ready (m_ready[1]),
        .level   (level[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int sz;
        logic [15:0] exp_d;

        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0;
            s_data[k]  = 16'h0;
            m_ready[k] = 1'b0;
            head[k]    = 0;
            tail[k]    = 0;
            emitted[k] = 0;
        end
        s_valid[1] = 1'b1;
        s_data[1]  = 16'h1234;
        m_ready[1] = 1'b1;

        // Reset state
        step();
        step();
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready[1]), 32'd0);
        check("rst_m_valid", 32'(m_valid[1]), 32'd0);
        check("rst_level", 32'(level[1]), 32'd0);
        check("rst_m_data", 32'(m_data[1]), 32'd0);
        check("rst_level_comb", 32'(level[0]), 32'd0);
        check("rst_s_ready_comb", 32'(s_ready[0]), 32'd0);
        rst = 1'b1;

        // First edge after release raises s_ready, accept on the next edge
        step();
        check("rel_s_ready", 32'(s_ready[1]), 32'd1);
        check("rel_m_valid", 32'(m_valid[1]), 32'd0);
        step();
        s_valid[1] = 1'b0;
        check("first_m_valid", 32'(m_valid[1]), 32'd1);
        check("first_m_data", 32'(m_data[1]), 32'h1234);
        check("first_level", 32'(level[1]), 32'd1);
        step();
        check("first_drain", 32'(m_valid[1]), 32'd0);
        check("first_drain_lvl", 32'(level[1]), 32'd0);

        // Back-to-back stream, no bubbles
        for (int i = 1; i <= 16; i++) begin
            s_valid[1] = 1'b1;
            s_data[1]  = 16'(i);
            check("bb_s_ready", 32'(s_ready[1]), 32'd1);
            if (i > 1) begin
                check("bb_m_valid", 32'(m_valid[1]), 32'd1);
                check("bb_m_data", 32'(m_data[1]), 32'(i - 1));
            end
            step();
        end
        s_valid[1] = 1'b0;
        check("bb_last_valid", 32'(m_valid[1]), 32'd1);
        check("bb_last_data", 32'(m_data[1]), 32'h10);
        step();
        check("bb_empty", 32'(m_valid[1]), 32'd0);

        // Fill under back-pressure
        m_ready[1] = 1'b0;
        s_valid[1] = 1'b1;
        s_data[1]  = 16'hA000;
        step();
        check("bp1_level", 32'(level[1]), 32'd1);
        check("bp1_s_ready", 32'(s_ready[1]), 32'd1);
        s_data[1] = 16'hA001;
        step();
        s_data[1] = 16'hA002;
        check("bp2_level", 32'(level[1]), 32'd2);
        check("bp2_s_ready", 32'(s_ready[1]), 32'd0);
        check("bp2_m_data", 32'(m_data[1]), 32'hA000);
        step();
        check("bp3_level", 32'(level[1]), 32'd2);
        check("bp3_m_data", 32'(m_data[1]), 32'hA000);
        check("bp3_s_ready", 32'(s_ready[1]), 32'd0);

        // FULL with both s_valid and m_ready: one out, nothing in
        m_ready[1] = 1'b1;
        step();
        m_ready[1] = 1'b0;
        check("full_both_level", 32'(level[1]), 32'd1);
        check("full_both_s_ready", 32'(s_ready[1]), 32'd1);
        check("full_both_m_data", 32'(m_data[1]), 32'hA001);
        step();
        s_valid[1] = 1'b0;
        check("refill_level", 32'(level[1]), 32'd2);
        check("refill_m_data", 32'(m_data[1]), 32'hA001);
        m_ready[1] = 1'b1;
        step();
        check("drain_a002", 32'(m_data[1]), 32'hA002);
        check("drain_a002_lvl", 32'(level[1]), 32'd1);
        step();
        check("drain_empty", 32'(m_valid[1]), 32'd0);
        check("drain_empty_lvl", 32'(level[1]), 32'd0);

        // Asynchronous reset while holding two beats
        m_ready[1] = 1'b0;
        s_valid[1] = 1'b1;
        s_data[1]  = 16'hA010;
        step();
        s_data[1] = 16'hA011;
        step();
        s_valid[1] = 1'b0;
        check("pre_rst_level", 32'(level[1]), 32'd2);
        #1 rst = 1'b0;
        #1;
        check("async_m_valid", 32'(m_valid[1]), 32'd0);
        check("async_s_ready", 32'(s_ready[1]), 32'd0);
        check("async_level", 32'(level[1]), 32'd0);
        check("async_m_data", 32'(m_data[1]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_stale", 32'(m_valid[1]), 32'd0);
        end
        m_ready[1] = 1'b0;
        step();

        // Random traffic on both variants
        cyc = 0;
        while ((emitted[0] < 10000 || emitted[1] < 10000) && cyc < 60000) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                sz = tail[k] - head[k];
                check("rnd_level", 32'(level[k]), 32'(sz));
                if (k == 1) begin
                    check("rnd_m_valid", 32'(m_valid[k]), 32'(sz > 0));
                    check("rnd_s_ready", 32'(s_ready[k]), 32'(sz < 2));
                end else begin
                    check("rnd_m_valid_comb", 32'(m_valid[k]), 32'((sz > 0) || s_valid[k]));
                    check("rnd_s_ready_comb", 32'(s_ready[k]), 32'(sz == 0));
                end
                if (m_valid[k]) begin
                    exp_d = (sz > 0) ? mdl[k][head[k] & 32'h7FFF] : s_data[k];
                    check("rnd_m_data", 32'(m_data[k]), 32'(exp_d));
                end
                acc[k] = s_valid[k] & s_ready[k];
                em[k]  = m_valid[k] & m_ready[k];
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) begin
                    mdl[k][tail[k] & 32'h7FFF] = s_data[k];
                    tail[k]++;
                end
                if (em[k]) begin
                    head[k]++;
                    emitted[k]++;
                end
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                sr_before[k] = s_ready[k];
                if (acc[k] || !s_valid[k]) begin
                    s_valid[k] = 1'($urandom_range(0, 1));
                    s_data[k]  = 16'($urandom());
                end
                m_ready[k] = 1'($urandom_range(0, 1));
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                check("sready_comb_path", 32'(s_ready[k]), 32'(sr_before[k]));
            end
            cyc++;
        end
        check("beats_comb", 32'(emitted[0] >= 10000), 32'd1);
        check("beats_fwd", 32'(emitted[1] >= 10000), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
